// File: rtl/rotate_sequencer.sv
// rotate_sequencer: multi-cycle circular shifter, one bit per clock, valid/ready in and out.
module rotate_sequencer #(
  parameter int N    = 8,
  parameter int AMTW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic [AMTW-1:0] in_amt,
  input  logic            in_dir,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic            busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]      state_q, state_d;
  logic [N-1:0]    data_q, data_d, rot;
  logic [AMTW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  assign rot = dir_q ? {data_q[N-2:0], data_q[N-1]} : {data_q[0], data_q[N-1:1]};
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: if (in_valid) begin
        data_d  = in_data;
        cnt_d   = in_amt;
        dir_d   = in_dir;
        state_d = (in_amt != '0) ? SHIFT : DONE;
      end
      SHIFT: if (abort) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        data_d  = rot;
        cnt_d   = cnt_q - AMTW'(1);
        state_d = (cnt_q == AMTW'(1)) ? DONE : SHIFT;
      end
      DONE: if (abort) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (out_ready) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_data  = data_q;
endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer: directed scenarios plus randomized traffic checked against a job-level model.
module tb_rotate_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_amt = '0;
  logic       in_dir = 1'b0;
  logic       abort = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       busy;
  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  rotate_sequencer #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Rotation by k places computed from a doubled word rather than stepwise.
  function automatic logic [7:0] rot8(input logic [7:0] d, input int k, input logic dr);
    logic [15:0] t;
    t = {d, d};
    return dr ? 8'((t << k) >> 8) : 8'(t >> k);
  endfunction

  // Job model: e counts cycles since accept; result becomes visible once e reaches amt.
  logic       m_active = 1'b0;
  logic [7:0] m_d = '0, m_hold = '0;
  logic       m_dir = 1'b0;
  int         m_amt = 0, m_e = 0;

  function automatic logic [7:0] exp_data();
    return m_active ? rot8(m_d, (m_e < m_amt) ? m_e : m_amt, m_dir) : m_hold;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_hold   <= '0;
      m_e      <= 0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_d      <= in_data;
        m_amt    <= int'(in_amt);
        m_dir    <= in_dir;
        m_e      <= 0;
      end
    end else if (abort || (m_e >= m_amt && out_ready)) begin
      m_active <= 1'b0;
      m_hold   <= exp_data();
    end else begin
      m_e <= m_e + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", in_ready, !m_active);
      chk("cyc_busy", busy, m_active);
      chk("cyc_out_valid", out_valid, m_active && m_e >= m_amt);
      chk("cyc_out_data", out_data, exp_data());
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic dr);
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    chk("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dr;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = 3'($urandom);
    in_dir   = 1'($urandom);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
    chk("wait_valid", out_valid, 1);
  endtask

  initial begin
    int n;
    logic [7:0] got;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", busy, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    // 1: right by one
    send(8'h81, 3'd1, 1'b0);
    chk("t1_valid_e0", out_valid, 0);
    @(negedge clk);
    chk("t1_valid_e1", out_valid, 1);
    chk("t1_data", out_data, 8'hC0);
    @(negedge clk);
    // 2: left by three, busy window
    send(8'h81, 3'd3, 1'b1);
    n = 0;
    got = '0;
    while (busy && n < 20) begin
      if (out_valid) got = out_data;
      n++;
      @(negedge clk);
    end
    chk("t2_busy_cycles", n, 4);
    chk("t2_data", got, 8'h0C);
    // 3: zero amount
    send(8'h81, 3'd0, 1'b0);
    chk("t3_valid", out_valid, 1);
    chk("t3_data", out_data, 8'h81);
    @(negedge clk);
    chk("t3_idle", busy, 0);
    // 4: back-pressure in DONE
    out_ready = 1'b0;
    send(8'hA5, 3'd7, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_data", out_data, 8'h4B);
      chk("t4_hold_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("t4_ready_hs", in_ready, 0);
    @(negedge clk);
    chk("t4_ready_after", in_ready, 1);
    chk("t4_valid_after", out_valid, 0);
    // 5: abort on second SHIFT cycle
    send(8'h55, 3'd5, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_ready", in_ready, 1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    chk("t5_no_valid", n, 0);
    send(8'h01, 3'd1, 1'b1);
    @(negedge clk);
    chk("t5_next_valid", out_valid, 1);
    chk("t5_next_data", out_data, 8'h02);
    @(negedge clk);
    // 6: asynchronous reset mid-SHIFT
    send(8'h3C, 3'd6, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 8'h00);
    chk("t6_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C, 3'd2, 1'b0);
    repeat (2) @(negedge clk);
    chk("t6_after_valid", out_valid, 1);
    chk("t6_after_data", out_data, 8'h0F);
    // randomized traffic, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      in_amt    = 3'($urandom);
      in_dir    = 1'($urandom);
      abort     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("final_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
